// File: rtl/arch_defs_pkg.sv
// Shared UART definitions: data width, bit index width, the UART state
// encoding used by both the transmitter and the receiver, and a helper
// that derives the clock-cycles-per-bit divisor.
package arch_defs_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int BIT_IDX_WIDTH = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        STOP2 = 3'd4
    } uart_state_t;

    // Integer-truncated divisor; never returns less than 1 so the baud
    // counter always has a legal terminal count.
    function automatic int clks_per_bit(input int clock_speed, input int baud_rate);
        int ratio;
        ratio = clock_speed / baud_rate;
        return (ratio < 1) ? 1 : ratio;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps, raising bit_tick during the last cycle of each bit period. A
// synchronous clear holds the count at 0 so every frame starts on a fresh
// bit boundary.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 208
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_WIDTH = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count;

    // Free-running bit-period counter, cleared on reset, on request and at wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

    assign bit_tick = (count == LAST_COUNT) && !clear;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per start strobe, LSB first, idle-high line,
// with an optional forced-low stop bit for framing-error injection.
// Build option: define UART_TX_TWO_STOP_EN to append a second (always high)
// stop bit, giving 11 bit times per frame instead of 10.
module uart_tx
    import arch_defs_pkg::*;
#(
    parameter int CLOCK_SPEED = 20_000_000,
    parameter int BAUD_RATE   = 9_600
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_parallel_data_in,
    input  logic                  tx_strobe_start,
    input  logic                  tx_force_frame_error,
    output logic                  tx_strobe_busy,
    output logic                  tx_serial_data_out
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_SPEED, BAUD_RATE);
    localparam logic [BIT_IDX_WIDTH-1:0] LAST_BIT = BIT_IDX_WIDTH'(DATA_WIDTH - 1);

    uart_state_t              state;
    uart_state_t              state_next;
    logic [DATA_WIDTH-1:0]    data_latched;
    logic                     force_latched;
    logic [BIT_IDX_WIDTH-1:0] bit_idx;
    logic [BIT_IDX_WIDTH-1:0] bit_idx_next;
    logic                     line_next;
    logic                     busy_next;
    logic                     bit_tick;
    logic                     start_accept;

    // Only a strobe seen while idle begins a frame; strobes mid-frame are dropped.
    assign start_accept = (state == IDLE) && tx_strobe_start;

    // Holding the timer cleared while idle makes each frame start at count 0.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .bit_tick (bit_tick)
    );

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each non-idle state lasts whole bit periods.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tx_strobe_start) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_tick && (bit_idx == LAST_BIT)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
`ifdef UART_TX_TWO_STOP_EN
                    state_next = STOP2;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                if (bit_tick) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit index advances once per data bit and restarts at every accepted frame.
    always_comb begin
        bit_idx_next = bit_idx;
        if (start_accept) begin
            bit_idx_next = '0;
        end else if ((state == DATA) && bit_tick) begin
            bit_idx_next = bit_idx + BIT_IDX_WIDTH'(1);
        end
    end

    // Frame contents are captured at the start strobe so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_latched  <= '0;
            force_latched <= 1'b0;
            bit_idx       <= '0;
        end else begin
            if (start_accept) begin
                data_latched  <= tx_parallel_data_in;
                force_latched <= tx_force_frame_error;
            end
            bit_idx <= bit_idx_next;
        end
    end

    // Output decode from the upcoming state so the registered line lines up with it.
    always_comb begin
        line_next = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            IDLE:    line_next = 1'b1;
            START:   line_next = 1'b0;
            DATA:    line_next = data_latched[bit_idx_next];
            STOP:    line_next = ~force_latched;
            STOP2:   line_next = 1'b1;
            default: line_next = 1'b1;
        endcase
    end

    // Output registers; the line idles high and busy is clear after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_serial_data_out <= 1'b1;
            tx_strobe_busy     <= 1'b0;
        end else begin
            tx_serial_data_out <= line_next;
            tx_strobe_busy     <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx at 2 MHz / 9600 baud (208 clocks per bit).
// Honours UART_TX_TWO_STOP_EN so the same bench covers both frame formats.
module tb_uart_tx;

    localparam int CLKS = 208;
`ifdef UART_TX_TWO_STOP_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] tx_parallel_data_in;
    logic       tx_strobe_start;
    logic       tx_force_frame_error;
    logic       tx_strobe_busy;
    logic       tx_serial_data_out;

    int assertCount;
    int failCount;
    int busyCycles;

    uart_tx #(
        .CLOCK_SPEED (2_000_000),
        .BAUD_RATE   (9_600)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .tx_parallel_data_in  (tx_parallel_data_in),
        .tx_strobe_start      (tx_strobe_start),
        .tx_force_frame_error (tx_force_frame_error),
        .tx_strobe_busy       (tx_strobe_busy),
        .tx_serial_data_out   (tx_serial_data_out)
    );

    // 100 MHz simulation clock; only the cycle count matters.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count cycles with busy high, sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_strobe_busy) begin
            busyCycles <= busyCycles + 1;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulse the start strobe for one cycle, then scramble the inputs mid-frame.
    task automatic applyStimulus(input logic [7:0] data, input logic force_err);
        @(negedge clk);
        tx_parallel_data_in  = data;
        tx_force_frame_error = force_err;
        tx_strobe_start      = 1'b1;
        busyCycles           = 0;
        @(negedge clk);
        tx_strobe_start      = 1'b0;
        tx_parallel_data_in  = ~data;
        tx_force_frame_error = ~force_err;
    endtask

    // Hand-derived line level for frame bit k: start, data LSB first, stop(s).
    function automatic logic expectedBit(input logic [7:0] data, input logic force_err, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return data[k-1];
        if (k == 9) return ~force_err;
        return 1'b1;
    endfunction

    // Wait (bounded) for busy to fall, then check frame length and idle line.
    task automatic waitFrameEnd(input string tag, input int expBusy);
        for (int i = 0; i < 4 * CLKS; i++) begin
            if (!tx_strobe_busy) break;
            @(negedge clk);
        end
        checkOutput({tag, "_busy_drop"}, 32'(tx_strobe_busy), 32'd0);
        checkOutput({tag, "_busy_len"}, 32'(busyCycles), 32'(expBusy));
        checkOutput({tag, "_idle_line"}, 32'(tx_serial_data_out), 32'd1);
    endtask

    // Send a frame, sample every bit mid-period, optionally re-strobe 100 cycles in.
    task automatic sendAndCheck(input string tag, input logic [7:0] data, input logic force_err,
                                input logic extraStrobe);
        applyStimulus(data, force_err);
        checkOutput({tag, "_busy_start"}, 32'(tx_strobe_busy), 32'd1);
        if (extraStrobe) begin
            repeat (99) @(negedge clk);
            tx_strobe_start = 1'b1;
            @(negedge clk);
            tx_strobe_start = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (103) @(negedge clk);
        end
        for (int k = 0; k < FRAME_BITS; k++) begin
            checkOutput($sformatf("%s_bit%0d", tag, k), 32'(tx_serial_data_out),
                        32'(expectedBit(data, force_err, k)));
            if (k != FRAME_BITS - 1) repeat (CLKS) @(negedge clk);
        end
        waitFrameEnd(tag, FRAME_BITS * CLKS);
    endtask

    // Main directed sequence.
    initial begin
        assertCount          = 0;
        failCount            = 0;
        busyCycles           = 0;
        reset                = 1'b0;
        tx_parallel_data_in  = 8'h00;
        tx_strobe_start      = 1'b0;
        tx_force_frame_error = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("rst_line", 32'(tx_serial_data_out), 32'd1);
        checkOutput("rst_busy", 32'(tx_strobe_busy), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_line", 32'(tx_serial_data_out), 32'd1);
        checkOutput("idle_busy", 32'(tx_strobe_busy), 32'd0);

        $display("[TB] frame 0xDD clean");
        sendAndCheck("dd", 8'hDD, 1'b0, 1'b0);

        $display("[TB] frame 0xDD forced stop error");
        sendAndCheck("dd_err", 8'hDD, 1'b1, 1'b0);

        $display("[TB] frame 0xA5 with ignored second strobe");
        sendAndCheck("a5_restrobe", 8'hA5, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("no_queue_busy", 32'(tx_strobe_busy), 32'd0);

        $display("[TB] frame 0x00");
        sendAndCheck("zero", 8'h00, 1'b0, 1'b0);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'h00, 1'b0);
        repeat (4 * CLKS + 100) @(negedge clk);
        checkOutput("abort_pre_line", 32'(tx_serial_data_out), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_line", 32'(tx_serial_data_out), 32'd1);
        checkOutput("abort_busy", 32'(tx_strobe_busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abort_no_resume", 32'(tx_strobe_busy), 32'd0);
        sendAndCheck("post_abort", 8'hDD, 1'b0, 1'b0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
